// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle for the RV32I instruction encoder.
//   Request side : in_valid/in_ready handshake carrying op, rd, rs1, rs2, imm.
//   Response side: out_valid/out_ready handshake carrying out_instr, out_err.
//   master : the client (issues requests, consumes encoded words).
//   slave  : the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs a structured RV32I instruction description into a
// 32-bit machine word, range-checking the immediate. Illegal ops and
// out-of-range immediates are replaced by a NOP (0x00000013) flagged with
// out_err. Results pass through a 2-entry output FIFO.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   bus (slave)         : request handshake in, encoded-word handshake out
//   enc_count/err_count : saturating counts of accepted / rejected requests
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
    OP_SLTU, OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_SLTI, OP_SLTIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH,
    OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR,
    OP_LUI, OP_AUIPC
  } op_e;

  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_J, F_U, F_BAD} fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [1:0]  DEPTH = 2'(FIFO_DEPTH);

  // ---------------- combinational encoder ----------------
  fmt_e        fmt;
  logic [2:0]  f3;
  logic [6:0]  opc;
  logic        alt;      // selects funct7 = 0100000 (SUB/SRA/SRAI)
  logic [31:0] imm;
  logic        fits_i, fits_b, fits_j, fits_sh;
  entry_t      enc;

  assign imm = bus.in_imm;
  // A value fits an N-bit signed field when all bits above N-1 replicate bit N-1.
  assign fits_i  = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fits_j  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign fits_sh = ~(|imm[31:5]);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    fmt = F_BAD;
    f3  = 3'b000;
    opc = 7'b0000000;
    alt = 1'b0;
    case (op_e'(bus.in_op))
      OP_ADD:   begin fmt = F_R;  f3 = 3'b000; end
      OP_SUB:   begin fmt = F_R;  f3 = 3'b000; alt = 1'b1; end
      OP_SLL:   begin fmt = F_R;  f3 = 3'b001; end
      OP_SLT:   begin fmt = F_R;  f3 = 3'b010; end
      OP_SLTU:  begin fmt = F_R;  f3 = 3'b011; end
      OP_XOR:   begin fmt = F_R;  f3 = 3'b100; end
      OP_SRL:   begin fmt = F_R;  f3 = 3'b101; end
      OP_SRA:   begin fmt = F_R;  f3 = 3'b101; alt = 1'b1; end
      OP_OR:    begin fmt = F_R;  f3 = 3'b110; end
      OP_AND:   begin fmt = F_R;  f3 = 3'b111; end
      OP_ADDI:  begin fmt = F_I;  f3 = 3'b000; opc = 7'b0010011; end
      OP_SLTI:  begin fmt = F_I;  f3 = 3'b010; opc = 7'b0010011; end
      OP_SLTIU: begin fmt = F_I;  f3 = 3'b011; opc = 7'b0010011; end
      OP_XORI:  begin fmt = F_I;  f3 = 3'b100; opc = 7'b0010011; end
      OP_ORI:   begin fmt = F_I;  f3 = 3'b110; opc = 7'b0010011; end
      OP_ANDI:  begin fmt = F_I;  f3 = 3'b111; opc = 7'b0010011; end
      OP_SLLI:  begin fmt = F_SH; f3 = 3'b001; end
      OP_SRLI:  begin fmt = F_SH; f3 = 3'b101; end
      OP_SRAI:  begin fmt = F_SH; f3 = 3'b101; alt = 1'b1; end
      OP_LB:    begin fmt = F_I;  f3 = 3'b000; opc = 7'b0000011; end
      OP_LH:    begin fmt = F_I;  f3 = 3'b001; opc = 7'b0000011; end
      OP_LW:    begin fmt = F_I;  f3 = 3'b010; opc = 7'b0000011; end
      OP_LBU:   begin fmt = F_I;  f3 = 3'b100; opc = 7'b0000011; end
      OP_LHU:   begin fmt = F_I;  f3 = 3'b101; opc = 7'b0000011; end
      OP_JALR:  begin fmt = F_I;  f3 = 3'b000; opc = 7'b1100111; end
      OP_SB:    begin fmt = F_S;  f3 = 3'b000; end
      OP_SH:    begin fmt = F_S;  f3 = 3'b001; end
      OP_SW:    begin fmt = F_S;  f3 = 3'b010; end
      OP_BEQ:   begin fmt = F_B;  f3 = 3'b000; end
      OP_BNE:   begin fmt = F_B;  f3 = 3'b001; end
      OP_BLT:   begin fmt = F_B;  f3 = 3'b100; end
      OP_BGE:   begin fmt = F_B;  f3 = 3'b101; end
      OP_BLTU:  begin fmt = F_B;  f3 = 3'b110; end
      OP_BGEU:  begin fmt = F_B;  f3 = 3'b111; end
      OP_JAL:   fmt = F_J;
      OP_LUI:   begin fmt = F_U;  opc = 7'b0110111; end
      OP_AUIPC: begin fmt = F_U;  opc = 7'b0010111; end
      default:  fmt = F_BAD;
    endcase
  end

  always_comb begin
    enc = '{instr: NOP, err: 1'b1};
    case (fmt)
      F_R:  enc = '{{1'b0, alt, 5'b0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011}, 1'b0};
      F_I:  if (fits_i)
              enc = '{{imm[11:0], bus.in_rs1, f3, bus.in_rd, opc}, 1'b0};
      F_SH: if (fits_sh)
              enc = '{{1'b0, alt, 5'b0, imm[4:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011}, 1'b0};
      F_S:  if (fits_i)
              enc = '{{imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], 7'b0100011}, 1'b0};
      F_B:  if (fits_b)
              enc = '{{imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3, imm[4:1], imm[11],
                       7'b1100011}, 1'b0};
      F_J:  if (fits_j)
              enc = '{{imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111}, 1'b0};
      F_U:  if (~(|imm[11:0]))
              enc = '{{imm[31:12], bus.in_rd, opc}, 1'b0};
      default: enc = '{instr: NOP, err: 1'b1};
    endcase
  end

  // ---------------- output FIFO and counters ----------------
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d, err_count_q, err_count_d;
  logic             push, pop;

  // Ready depends on occupancy alone, so there is no combinational path from out_ready.
  assign bus.in_ready  = (count_q < DEPTH);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_err   = mem_q[rd_ptr_q].err;
  assign enc_count     = enc_count_q;
  assign err_count     = err_count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc;
      wr_ptr_d        = ~wr_ptr_q;
      if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_W'(1);
      if (enc.err && err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the FIFO storage is reset as well because out_instr reads the
      // head entry directly and must show 0 out of reset; at two entries the
      // reset cost is negligible, unlike a real RAM.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed in always_comb, independent of statement order.
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes hand-computed expected
// words into a queue on accept; a monitor pops and compares on every transfer.
module tb_instr_encoder;
  localparam int CNT_W = 4;          // small so counter saturation is reachable
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] enc_count, err_count;

  instr_encoder_if bus ();

  instr_encoder #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;
  logic [32:0] sb_q [$];             // {err, instr}
  logic [CNT_W-1:0] exp_enc = '0, exp_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready
  // are both high at the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_popped++;
      if (sb_q.size() == 0) begin
        check("unexpected_output", bus.out_instr, 32'hxxxx_xxxx);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("out_instr", bus.out_instr, e[31:0]);
        check("out_err", {31'b0, bus.out_err}, {31'b0, e[32]});
      end
    end
  end

  // Drives one request starting just after a rising edge; returns just after
  // the accepting edge.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_i, input logic exp_e);
    int  waited = 0;
    bit  accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) accepted = 1;
      else waited++;
    end
    if (accepted) begin
      sb_q.push_back({exp_e, exp_i});
      if (exp_enc != MAXC) exp_enc++;
      if (exp_e && exp_err != MAXC) exp_err++;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb_q.size() != 0 || bus.out_valid === 1'b1) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_done", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int popped_before;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);

    // ADDI x10, x0, 5 (rs2 junk must be ignored); 1-cycle latency
    send(6'd10, 5'd10, 5'd0, 5'd31, 32'd5, 32'h0050_0513, 1'b0);
    check("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("lat_out_instr", bus.out_instr, 32'h0050_0513);
    check("enc_count_1", 32'(enc_count), 32'd1);

    // R-type back-to-back, SRAI
    send(6'd0,  5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    send(6'd1,  5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    send(6'd16, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0);
    // S, B, U (junk in unused fields)
    send(6'd26, 5'd9, 5'd2, 5'd5, 32'd8, 32'h0051_2423, 1'b0);
    send(6'd27, 5'd7, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3, 1'b0);
    send(6'd35, 5'd5, 5'd7, 5'd9, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    // Rejects
    send(6'd10, 5'd1, 5'd1, 5'd0, 32'd2048, NOP, 1'b1);
    send(6'd27, 5'd0, 5'd1, 5'd2, 32'd3, NOP, 1'b1);
    send(6'd40, 5'd1, 5'd1, 5'd1, 32'd0, NOP, 1'b1);
    check("err_count_3", 32'(err_count), 32'd3);
    check("enc_count_10", 32'(enc_count), 32'd10);

    // Immediate boundaries and remaining formats
    send(6'd10, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h8000_0013, 1'b0);
    send(6'd10, 5'd0, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0013, 1'b0);
    send(6'd14, 5'd1, 5'd1, 5'd0, 32'd32, NOP, 1'b1);
    send(6'd14, 5'd1, 5'd1, 5'd0, 32'd31, 32'h01F0_9093, 1'b0);
    send(6'd33, 5'd1, 5'd3, 5'd4, 32'd8, 32'h0080_00EF, 1'b0);
    send(6'd33, 5'd1, 5'd0, 5'd0, 32'd1048576, NOP, 1'b1);
    send(6'd34, 5'd1, 5'd5, 5'd6, 32'd0, 32'h0002_80E7, 1'b0);
    send(6'd35, 5'd5, 5'd0, 5'd0, 32'h1234_5001, NOP, 1'b1);
    check("enc_count_sat", 32'(enc_count), 32'(MAXC));
    check("err_count_model", 32'(err_count), 32'(exp_err));
    drain();

    // Backpressure: two fill the FIFO, third waits until out_ready returns
    popped_before = n_popped;
    bus.out_ready = 1'b0;
    send(6'd4, 5'd8, 5'd6, 5'd7, 32'd0, 32'h0073_7433, 1'b0);   // AND x8,x6,x7
    send(6'd2, 5'd8, 5'd6, 5'd7, 32'd0, 32'h0073_4433, 1'b0);   // XOR x8,x6,x7
    check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    fork
      send(6'd3, 5'd8, 5'd6, 5'd7, 32'd0, 32'h0073_6433, 1'b0); // OR x8,x6,x7
      begin
        repeat (2) begin
          @(posedge clk); #1;
          check("bp_hold_ready", {31'b0, bus.in_ready}, 32'd0);
          check("bp_hold_instr", bus.out_instr, 32'h0073_7433);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_pop_count", 32'(n_popped - popped_before), 32'd3);
    check("enc_count_held_sat", 32'(enc_count), 32'(exp_enc));

    // Reset with two buffered entries and a request in flight
    bus.out_ready = 1'b0;
    send(6'd10, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(6'd10, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    bus.in_valid = 1'b1; bus.in_op = 6'd10; bus.in_imm = 32'd3;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    exp_enc = '0; exp_err = '0;
    check("rr_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rr_out_instr", bus.out_instr, 32'd0);
    check("rr_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rr_enc_count", 32'(enc_count), 32'd0);
    check("rr_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    check("rr_enc_count_later", 32'(enc_count), 32'd0);

    // Normal operation resumes after reset
    bus.out_ready = 1'b1;
    send(6'd21, 5'd4, 5'd2, 5'd0, 32'd16, 32'h0101_2203, 1'b0); // LW x4,16(x2)
    check("post_rst_enc_count", 32'(enc_count), 32'd1);
    drain();
    check("final_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts a structured RV32I instruction description into a 32-bit machine word; the inverse of the pipeline's decode path.
- Inputs: operation enum, register indices and a 32-bit immediate. The block range-checks the immediate and packs the fields per the base ISA formats (R/I/S/B/U/J).
- Results go through a 2-entry output FIFO with valid/ready on both sides.
- Used by the self-test program loader and by the debug console to inject instructions into instruction memory.

Parameters:
FIFO_DEPTH, 2, output buffer entries (fixed at 2; other values are not supported)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_op  input  6  operation enum: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ADDI, 11 XORI, 12 ORI, 13 ANDI, 14 SLLI, 15 SRLI, 16 SRAI, 17 SLTI, 18 SLTIU, 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW, 27 BEQ, 28 BNE, 29 BLT, 30 BGE, 31 BLTU, 32 BGEU, 33 JAL, 34 JALR, 35 LUI, 36 AUIPC; 37-63 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  immediate as a signed byte offset or value; for U-type, the full 32-bit value
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_instr  output  32  encoded instruction at FIFO head
out_err  output  1  head entry was rejected and replaced by a NOP
enc_count  output  CNT_W  number of requests accepted, saturating
err_count  output  CNT_W  number of requests rejected, saturating

Behaviour:
- Reset (synchronous, takes priority over all other activity):
  - FIFO emptied; out_valid=0, out_instr=0, out_err=0.
  - enc_count=0, err_count=0; in_ready=1 in the cycle after reset deasserts.
  - A request presented in the same cycle as reset is dropped and not counted.
- Accept: a request is accepted when in_valid and in_ready are both high at a rising edge.
  - in_ready is high when the FIFO count is below 2. It depends only on count, not on out_ready; there is no combinational ready path.
- Encoding is combinational from the inputs. The result is written to the FIFO tail at the accepting edge.
  - Latency is 1 cycle: out_valid rises the cycle after the accept when the FIFO was empty.
- Pop: the head is removed at an edge where out_valid and out_ready are both high.
  - Push and pop in the same cycle (count 1) leave count at 1 and present the new entry as head next cycle.
  - Order is strict FIFO.
  - out_instr and out_err hold their value while out_valid=1 and out_ready=0.
- Field packing, standard RV32I:
  - R-type opcode 0110011: funct7=0100000 for SUB and SRA, otherwise 0000000.
  - I-type ALU opcode 0010011; loads 0000011; JALR 1100111 with funct3 0.
  - S-type opcode 0100011; B-type 1100011; JAL 1101111; LUI 0110111; AUIPC 0010111.
  - Fields unused by a format are driven 0 regardless of the inputs (for example, rs2 for I-type, and rs1/rs2 for U/J).
- Range checks; violation means reject:
  - I, S and JALR: in_imm in -2048..2047.
  - SLLI/SRLI/SRAI: in_imm in 0..31. Encoded as shamt in [24:20]; [31:25] is 0000000, or 0100000 for SRAI.
  - B: in_imm in -4096..4094 and in_imm[0]=0.
  - JAL: in_imm in -1048576..1048574 and in_imm[0]=0.
  - LUI/AUIPC: in_imm[11:0]=0. Bits [31:12] are placed in instr[31:12].
- Reject (illegal op or range violation):
  - The entry is still pushed, with out_instr=0x00000013 (NOP) and out_err=1.
  - Both enc_count and err_count increment.
- Counters increment by 1 per accepted request and saturate at all-ones (no wrap).

Test Plan:
- ADDI rd=10, rs1=0, imm=5 with out_ready=1 -> out_instr=0x00500513 one cycle later, out_err=0, enc_count=1.
- ADD 3,1,2 then SUB 3,1,2 back-to-back -> 0x002081B3 then 0x402081B3 in order; SRAI 1,1,3 -> 0x4030D093.
- SW rs2=5, rs1=2, imm=8 -> 0x00512423; BEQ rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; LUI rd=5, imm=0x12345000 -> 0x123452B7.
- Each of the following -> 0x00000013 with out_err=1, err_count=3 after all three:
  - ADDI imm=2048
  - BEQ imm=3
  - op=40
- Backpressure: hold out_ready=0 and push 3 requests -> in_ready drops after 2 accepts, the third is held. Release out_ready -> all three emerge in order with no loss or duplication.
- Reset asserted with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, counters 0, in_ready=1, the in-flight request is not counted.
